// File: rtl/dout_display_receiver_pkg.sv
// Shared digit codes, FSM states, request record and the 7-segment decoder
// for the CPU output-port display receiver.
package dout_display_receiver_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_MINUS = 4'hB;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sgn;
  } req_t;

  // Active-high {g,f,e,d,c,b,a} pattern for a digit code.
  function automatic logic [6:0] seg7(input logic [3:0] dig);
    logic [6:0] p;
    case (dig)
      4'd0:      p = 7'h3F;
      4'd1:      p = 7'h06;
      4'd2:      p = 7'h5B;
      4'd3:      p = 7'h4F;
      4'd4:      p = 7'h66;
      4'd5:      p = 7'h6D;
      4'd6:      p = 7'h7D;
      4'd7:      p = 7'h07;
      4'd8:      p = 7'h7F;
      4'd9:      p = 7'h6F;
      DIG_MINUS: p = 7'h40;
      default:   p = 7'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dout_display_receiver_if.sv
// CPU output port as seen by the display receiver: data/valid/mode towards
// the receiver, status back towards the CPU.
interface dout_display_receiver_if;
  logic [7:0] dout;
  logic       dval;
  logic       signed_mode;
  logic       busy;
  logic       overrun;

  modport master (output dout, dval, signed_mode, input busy, overrun);
  modport slave  (input dout, dval, signed_mode, output busy, overrun);
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-add-3 binary to BCD converter: 8 cycles after start, done
// pulses and the BCD outputs carry the final result for that cycle only.
module bin_to_bcd_serial (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] mag,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       done
);

  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        act_q, act_d;

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    act_d = act_q;
    done  = 1'b0;
    adj   = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bin_d = mag;
      bcd_d = '0;
      cnt_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
      cnt_d          = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done  = 1'b1;
        act_d = 1'b0;
      end
    end
  end

  // Outputs come from the next-state value so the caller can capture the
  // result on the same edge as the eighth shift.
  assign hundreds = bcd_d[11:8];
  assign tens     = bcd_d[7:4];
  assign units    = bcd_d[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/dout_display_receiver.sv
// Captures CPU output bytes on dval rising edges, converts them to decimal and
// drives a 4-digit multiplexed 7-segment display (sign, hundreds, tens, units).
module dout_display_receiver
  import dout_display_receiver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  dout_display_receiver_if.slave        cpu,
  output logic [6:0]                    seg,
  output logic [3:0]                    an
);

  localparam int unsigned CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_ZERO  = seg7(4'd0);
  localparam logic [6:0] SEG_RST   = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [3:0] AN_RST    = SEG_ACTIVE_LOW ? 4'b1110 : 4'b0001;

  state_t           state_q, state_d;
  logic             dval_q, dval_d;
  req_t             pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             overrun_q, overrun_d;
  logic             neg_q, neg_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [1:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  req_t       cur, req;
  logic       rise, start, done;
  logic [7:0] mag;
  logic [3:0] bcd_h, bcd_t, bcd_u;

  bin_to_bcd_serial u_bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mag      (mag),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u),
    .done     (done)
  );

  always_comb begin
    state_d    = state_q;
    dval_d     = cpu.dval;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    neg_d      = neg_q;
    digit_d    = digit_q;
    cur        = {cpu.dout, cpu.signed_mode};
    rise       = cpu.dval & ~dval_q;
    start      = 1'b0;
    req        = cur;

    case (state_q)
      ST_IDLE: begin
        // A waiting request has priority; a coincident rise refills the slot.
        if (pend_vld_q) begin
          req        = pend_q;
          start      = 1'b1;
          pend_vld_d = 1'b0;
          if (rise) begin
            pend_d     = cur;
            pend_vld_d = 1'b1;
          end
        end else if (rise) begin
          start = 1'b1;
        end
        if (start) begin
          state_d = ST_CONV;
          neg_d   = req.sgn & req.data[7];
        end
      end
      ST_CONV: begin
        if (rise) begin
          pend_d     = cur;
          pend_vld_d = 1'b1;
          if (pend_vld_q) overrun_d = 1'b1;
        end
        if (done) begin
          digit_d[3] = neg_q ? DIG_MINUS : DIG_BLANK;
          digit_d[2] = (bcd_h == 4'd0) ? DIG_BLANK : bcd_h;
          digit_d[1] = (bcd_h == 4'd0 && bcd_t == 4'd0) ? DIG_BLANK : bcd_t;
          digit_d[0] = bcd_u;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mag = (req.sgn & req.data[7]) ? (~req.data + 8'd1) : req.data;
  end

  // Digit scan: an and seg are both registered from the same select value.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    sel_d = (cnt_q == CNT_LAST) ? sel_q + 2'd1 : sel_q;
    an_d  = SEG_ACTIVE_LOW ? ~(4'b0001 << sel_q) : (4'b0001 << sel_q);
    seg_d = SEG_ACTIVE_LOW ? ~seg7(digit_q[sel_q]) : seg7(digit_q[sel_q]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dval_q     <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      neg_q      <= 1'b0;
      digit_q    <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};
      sel_q      <= '0;
      cnt_q      <= '0;
      an_q       <= AN_RST;
      seg_q      <= SEG_RST;
    end else begin
      state_q    <= state_d;
      dval_q     <= dval_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      neg_q      <= neg_d;
      digit_q    <= digit_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign cpu.busy    = (state_q == ST_CONV);
  assign cpu.overrun = overrun_q;
  assign seg         = seg_q;
  assign an          = an_q;

endmodule

// File: tb/tb_dout_display_receiver.sv
// Bench for dout_display_receiver: an active-low instance and an active-high
// instance share stimulus; results are compared with an arithmetic model.
module tb_dout_display_receiver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    busy_prev <= ifc.busy;
    if (ifc.busy && !busy_prev) busy_rises <= busy_rises + 1;
  end

  dout_display_receiver_if ifc ();
  dout_display_receiver_if ifh ();
  assign ifh.dout        = ifc.dout;
  assign ifh.dval        = ifc.dval;
  assign ifh.signed_mode = ifc.signed_mode;

  dout_display_receiver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk), .reset_n (reset_n), .cpu (ifc), .seg (seg0), .an (an0));

  dout_display_receiver #(.REFRESH_DIV(3), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk), .reset_n (reset_n), .cpu (ifh), .seg (seg1), .an (an1));

  typedef struct {
    logic [7:0] d;
    logic       sm;
    string      exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] char_pat(input byte c);
    logic [6:0] dig [10];
    dig = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (c == 8'h2D) return 7'h40;
    if (c >= 8'h30 && c <= 8'h39) return dig[c - 8'h30];
    return 7'h00;
  endfunction

  // s[0]=sign .. s[3]=units; slot k of the result holds the pattern for an bit k.
  function automatic logic [27:0] disp_pats(input string s, input bit active_low);
    logic [27:0] p;
    p = {char_pat(s[0]), char_pat(s[1]), char_pat(s[2]), char_pat(s[3])};
    return active_low ? ~p : p;
  endfunction

  function automatic string fmt(input logic [7:0] d, input bit sm);
    int v, m, h, t, u;
    string s;
    v = sm ? int'($signed(d)) : int'(d);
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    s = "    ";
    if (v < 0) s.putc(0, 8'h2D);
    if (h != 0) s.putc(1, byte'(48 + h));
    if (h != 0 || t != 0) s.putc(2, byte'(48 + t));
    s.putc(3, byte'(48 + u));
    return s;
  endfunction

  task automatic read_disp(input bit inst, output logic [27:0] got);
    logic [3:0] oh;
    bit seen [4];
    int nseen = 0;
    got = '0;
    for (int i = 0; i < 40 && nseen < 4; i++) begin
      @(negedge clk);
      oh = inst ? an1 : ~an0;
      for (int k = 0; k < 4; k++) begin
        if (oh == (4'b0001 << k)) begin
          got[7*k +: 7] = inst ? seg1 : seg0;
          if (!seen[k]) nseen++;
          seen[k] = 1'b1;
        end
      end
    end
    chk("mux_all_digits_seen", nseen, 4);
  endtask

  task automatic check_disp(input string name, input string exp);
    logic [27:0] got;
    read_disp(1'b0, got);
    chk({name, "_lo"}, {4'h0, got}, {4'h0, disp_pats(exp, 1'b1)});
    read_disp(1'b1, got);
    chk({name, "_hi"}, {4'h0, got}, {4'h0, disp_pats(exp, 1'b0)});
  endtask

  task automatic pulse(input logic [7:0] d, input bit sm, input int w, output int c);
    @(negedge clk);
    ifc.dout = d;
    ifc.signed_mode = sm;
    ifc.dval = 1'b1;
    c = int'(cyc) + 1;
    repeat (w) begin
      @(negedge clk);
      ifc.dout = 8'($urandom);
      ifc.signed_mode = 1'($urandom);
    end
    ifc.dval = 1'b0;
  endtask

  task automatic wait_idle();
    int idle = 0;
    for (int i = 0; i < 80 && idle < 3; i++) begin
      @(negedge clk);
      idle = ifc.busy ? 0 : idle + 1;
    end
    chk("wait_idle_bound", idle, 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ifc.dval = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int c, n, r0;
    logic [3:0] prev, exp_an;
    logic [10:0] act;
    string dig_str;
    logic found;

    ifc.dout = '0;
    ifc.dval = 1'b0;
    ifc.signed_mode = 1'b0;

    vecs.push_back('{d: 8'd255, sm: 1'b0, exp: " 255"});
    vecs.push_back('{d: 8'h80,  sm: 1'b1, exp: "-128"});
    vecs.push_back('{d: 8'hFF,  sm: 1'b1, exp: "-  1"});
    vecs.push_back('{d: 8'd0,   sm: 1'b0, exp: "   0"});
    vecs.push_back('{d: 8'd0,   sm: 1'b1, exp: "   0"});
    vecs.push_back('{d: 8'd127, sm: 1'b1, exp: " 127"});
    vecs.push_back('{d: 8'd100, sm: 1'b0, exp: " 100"});
    vecs.push_back('{d: 8'd10,  sm: 1'b0, exp: "  10"});
    vecs.push_back('{d: 8'd9,   sm: 1'b1, exp: "   9"});
    vecs.push_back('{d: 8'd250, sm: 1'b1, exp: "-  6"});
    vecs.push_back('{d: 8'h81,  sm: 1'b1, exp: "-127"});
    vecs.push_back('{d: 8'h80,  sm: 1'b0, exp: " 128"});
    vecs.push_back('{d: 8'd200, sm: 1'b0, exp: " 200"});

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_an_lo", an0, 4'b1110);
    chk("rst_seg_lo", seg0, 7'b1000000);
    chk("rst_an_hi", an1, 4'b0001);
    chk("rst_seg_hi", seg1, 7'h3F);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_overrun", ifc.overrun, 1'b0);

    // Single conversion: busy length and result
    pulse(8'd255, 1'b0, 1, c);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (ifc.busy) n++;
    end
    chk("busy_cycles", n, 8);
    check_disp("disp_255", " 255");

    // Table of values
    foreach (vecs[i]) begin
      pulse(vecs[i].d, vecs[i].sm, 1 + int'($urandom_range(2)), c);
      wait_idle();
      check_disp("vec", vecs[i].exp);
    end
    chk("no_overrun_after_table", ifc.overrun, 1'b0);

    // Requests during conversion: latest pending wins, overrun set
    do_reset();
    r0 = busy_rises;
    pulse(8'd42, 1'b0, 1, c);
    pulse(8'd7, 1'b0, 1, c);
    pulse(8'd9, 1'b0, 1, c);
    wait_idle();
    chk("pend_conversions", busy_rises - r0, 2);
    chk("pend_overrun", ifc.overrun, 1'b1);
    check_disp("pend_latest", "   9");

    // Held-high dval triggers once
    do_reset();
    r0 = busy_rises;
    pulse(8'd77, 1'b0, 50, c);
    wait_idle();
    chk("held_conversions", busy_rises - r0, 1);
    chk("held_overrun", ifc.overrun, 1'b0);
    check_disp("held", "  77");

    // Reset mid-conversion
    do_reset();
    pulse(8'd255, 1'b0, 1, c);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_an_lo", an0, 4'b1110);
    chk("midrst_seg_lo", seg0, 7'b1000000);
    chk("midrst_an_hi", an1, 4'b0001);
    chk("midrst_seg_hi", seg1, 7'h3F);
    chk("midrst_busy", ifc.busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_busy_after", ifc.busy, 1'b0);
    check_disp("midrst_disp", "   0");

    // Scan order and dwell with -128 shown
    do_reset();
    pulse(8'h80, 1'b1, 1, c);
    wait_idle();
    dig_str = "-128";
    found = 1'b0;
    prev = an0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && an0 == 4'b1110) found = 1'b1;
      prev = an0;
    end
    chk("scan_sync", found, 1'b1);
    for (int s = 0; s < 5; s++) begin
      exp_an = ~(4'b0001 << (s % 4));
      for (int j = 0; j < 4; j++) begin
        if (s > 0 || j > 0) @(negedge clk);
        if (j == 0 || {an0, seg0} !== {exp_an, ~char_pat(dig_str[3 - (s % 4)])})
          act = {an0, seg0};
      end
      chk("scan_slot", act, {exp_an, ~char_pat(dig_str[3 - (s % 4)])});
    end

    // Randomized bursts against the transaction model
    for (int trial = 0; trial < 25; trial++) begin
      int busy_until, np;
      bit pend_v, ovr;
      logic [7:0] pend_d, last_d, d;
      bit pend_sm, last_sm, sm;
      do_reset();
      busy_until = -100;
      pend_v = 1'b0;
      ovr = 1'b0;
      pend_d = '0;
      pend_sm = 1'b0;
      last_d = 8'd0;
      last_sm = 1'b0;
      np = 3 + int'($urandom_range(3));
      for (int p = 0; p < np; p++) begin
        repeat ($urandom_range(9)) @(negedge clk);
        d = 8'($urandom);
        sm = 1'($urandom);
        pulse(d, sm, 1 + int'($urandom_range(2)), c);
        // A conversion started at edge s occupies edges s..s+8; a waiting
        // request starts on the edge after that.
        if (pend_v && busy_until + 1 <= c) begin
          busy_until = busy_until + 9;
          last_d = pend_d;
          last_sm = pend_sm;
          pend_v = 1'b0;
        end
        if (c <= busy_until) begin
          if (pend_v) ovr = 1'b1;
          pend_d = d;
          pend_sm = sm;
          pend_v = 1'b1;
        end else begin
          busy_until = c + 8;
          last_d = d;
          last_sm = sm;
        end
      end
      if (pend_v) begin
        last_d = pend_d;
        last_sm = pend_sm;
      end
      wait_idle();
      chk("rand_overrun", ifc.overrun, ovr);
      check_disp("rand_disp", fmt(last_d, last_sm));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
